// File: rtl/decode_stage_v2.sv
// Decode stage: classifies instructions, blocks RAW/WAW hazards via a
// pending-write scoreboard, and buffers decoded records in an output FIFO.
module decode_stage_v2 #(
  parameter int OPCODE_WIDTH = 7,
  parameter int PRIM_WIDTH   = 5,
  parameter int SEC_WIDTH    = 16,
  parameter int DEPTH        = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    isBranch_i,
  input  logic                    instructionFormat_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [PRIM_WIDTH-1:0]   primOperand_i,
  input  logic [SEC_WIDTH-1:0]    secOperand_i,
  input  logic                    wbValid_i,
  input  logic [PRIM_WIDTH-1:0]   wbReg_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [OPCODE_WIDTH-1:0] opcode_o,
  output logic [PRIM_WIDTH-1:0]   primOperand_o,
  output logic [SEC_WIDTH-1:0]    secOperand_o,
  output logic [1:0]              functionType_o,
  output logic                    pRead_o,
  output logic                    pWrite_o,
  output logic                    sRead_o,
  output logic                    illegal_o
);

  localparam int NUM_REGS = 2**PRIM_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [PRIM_WIDTH-1:0]   prim;
    logic [SEC_WIDTH-1:0]    sec;
    logic [1:0]              ftype;
    logic                    pread;
    logic                    pwrite;
    logic                    sread;
    logic                    illegal;
  } rec_t;

  rec_t                mem [DEPTH];
  rec_t                dec;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] set_mask;
  logic                hazard;
  logic                full;
  logic                push;
  logic                pop;

  always_comb begin
    dec         = '0;
    dec.opcode  = opcode_i;
    dec.prim    = primOperand_i;
    dec.sec     = secOperand_i;
    if (isBranch_i) begin
      case (opcode_i)
        OPCODE_WIDTH'(0): ;
        OPCODE_WIDTH'(1): begin
          dec.ftype = 2'd3;
          dec.sread = 1'b1;
        end
        OPCODE_WIDTH'(2): begin
          dec.ftype = 2'd3;
          dec.pread = 1'b1;
          dec.sread = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (opcode_i)
        OPCODE_WIDTH'(0): ;
        OPCODE_WIDTH'(1),
        OPCODE_WIDTH'(2),
        OPCODE_WIDTH'(3): begin
          dec.ftype  = 2'd1;
          dec.pread  = 1'b1;
          dec.pwrite = 1'b1;
          dec.sread  = !instructionFormat_i;
        end
        OPCODE_WIDTH'(4),
        OPCODE_WIDTH'(5): begin
          dec.ftype  = 2'd2;
          dec.pwrite = 1'b1;
          dec.sread  = !instructionFormat_i;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Same-cycle writeback is bypassed into the hazard check
  assign wb_mask  = wbValid_i ? (NUM_REGS'(1) << wbReg_i) : '0;
  assign pend_eff = pending & ~wb_mask;

  assign hazard = valid_i && (
      ((dec.pread || dec.pwrite) && pend_eff[primOperand_i]) ||
      (dec.sread && !instructionFormat_i &&
       pend_eff[secOperand_i[PRIM_WIDTH-1:0]]));

  assign full     = (count == CW'(DEPTH));
  assign ready_o  = !full && !hazard;
  assign valid_o  = (count != '0);
  assign push     = valid_i && ready_o;
  assign pop      = valid_o && ready_i;
  assign set_mask = (push && dec.pwrite) ? (NUM_REGS'(1) << primOperand_i) : '0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pending <= '0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pending <= pend_eff | set_mask;
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign opcode_o       = mem[rd_ptr].opcode;
  assign primOperand_o  = mem[rd_ptr].prim;
  assign secOperand_o   = mem[rd_ptr].sec;
  assign functionType_o = mem[rd_ptr].ftype;
  assign pRead_o        = mem[rd_ptr].pread;
  assign pWrite_o       = mem[rd_ptr].pwrite;
  assign sRead_o        = mem[rd_ptr].sread;
  assign illegal_o      = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_decode_stage_v2.sv
// Scoreboard bench for decode_stage_v2: expected records queued on accept,
// compared against the FIFO head on each downstream handshake.
module tb_decode_stage_v2;

  localparam int OW = 7;
  localparam int PW = 5;
  localparam int SW = 16;

  typedef logic [OW+PW+SW+6-1:0] rec_t;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic          ready_o;
  logic          isBranch_i;
  logic          instructionFormat_i;
  logic [OW-1:0] opcode_i;
  logic [PW-1:0] primOperand_i;
  logic [SW-1:0] secOperand_i;
  logic          wbValid_i;
  logic [PW-1:0] wbReg_i;
  logic          valid_o;
  logic          ready_i;
  logic [OW-1:0] opcode_o;
  logic [PW-1:0] primOperand_o;
  logic [SW-1:0] secOperand_o;
  logic [1:0]    functionType_o;
  logic          pRead_o;
  logic          pWrite_o;
  logic          sRead_o;
  logic          illegal_o;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock_i = ~clock_i;

  decode_stage_v2 #(
    .OPCODE_WIDTH(OW), .PRIM_WIDTH(PW), .SEC_WIDTH(SW), .DEPTH(2)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .isBranch_i(isBranch_i), .instructionFormat_i(instructionFormat_i),
    .opcode_i(opcode_i), .primOperand_i(primOperand_i),
    .secOperand_i(secOperand_i),
    .wbValid_i(wbValid_i), .wbReg_i(wbReg_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .opcode_o(opcode_o), .primOperand_o(primOperand_o),
    .secOperand_o(secOperand_o), .functionType_o(functionType_o),
    .pRead_o(pRead_o), .pWrite_o(pWrite_o), .sRead_o(sRead_o),
    .illegal_o(illegal_o)
  );

  // {ftype, pread, pwrite, sread, illegal}
  function automatic logic [5:0] model(input logic br, input logic fmt,
                                       input logic [OW-1:0] op);
    if (br) begin
      if (op == 0) return 6'b00_0000;
      if (op == 1) return 6'b11_0010;
      if (op == 2) return 6'b11_1010;
      return 6'b00_0001;
    end
    if (op == 0) return 6'b00_0000;
    if (op >= 1 && op <= 3) return {2'd1, 1'b1, 1'b1, ~fmt, 1'b0};
    if (op == 4 || op == 5) return {2'd2, 1'b0, 1'b1, ~fmt, 1'b0};
    return 6'b00_0001;
  endfunction

  always @(negedge clock_i) begin
    rec_t e;
    rec_t act;
    if (!reset_i) begin
      if (valid_o && ready_i) begin
        n_cmp++;
        act = {opcode_o, primOperand_o, secOperand_o, functionType_o,
               pRead_o, pWrite_o, sRead_o, illegal_o};
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_empty: got %h, required no output", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            n_bad++;
            $display("FAIL head_record: got %h, required %h", act, e);
          end
        end
      end
      if (valid_i && ready_o)
        q.push_back({opcode_i, primOperand_i, secOperand_i,
                     model(isBranch_i, instructionFormat_i, opcode_i)});
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic fmt,
                       input int op, input int prim, input int sec);
    valid_i             = v;
    isBranch_i          = br;
    instructionFormat_i = fmt;
    opcode_i            = OW'(op);
    primOperand_i       = PW'(prim);
    secOperand_i        = SW'(sec);
    #1;
  endtask

  task automatic wb(input logic v, input int r);
    wbValid_i = v;
    wbReg_i   = PW'(r);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    ready_i = 1'b1;
    wb(0, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if ({valid_o, opcode_o, primOperand_o, secOperand_o, functionType_o,
         pRead_o, pWrite_o, sRead_o, illegal_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b op=%0d type=%0d, required all 0",
               valid_o, opcode_o, functionType_o);
    end
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, required 1", ready_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_add();
    drive(1, 0, 0, 1, 3, 4);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL add_ready: got %b, required 1", ready_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({valid_o, functionType_o, pRead_o, pWrite_o, sRead_o, illegal_o}
        !== {1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL add_decode: valid=%b type=%0d pr=%b pw=%b sr=%b ill=%b",
               valid_o, functionType_o, pRead_o, pWrite_o, sRead_o, illegal_o);
    end
  endtask

  task automatic test_raw();
    drive(1, 0, 0, 2, 6, 3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL raw_stall: cycle %0d ready=%b, required 0", i, ready_o);
      end
      tick();
    end
    wb(1, 3);
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL raw_bypass: ready=%b, required 1", ready_o);
    end
    tick();
    wb(0, 0);
    drive(1, 1, 1, 1, 0, 6);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL branch_imm_nohaz: ready=%b, required 1", ready_o);
    end
    tick();
    drive(1, 1, 1, 2, 6, 0);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL branch_pread_haz: ready=%b, required 0", ready_o);
    end
    tick();
  endtask

  task automatic test_illegal();
    drive(1, 0, 0, 9, 6, 6);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_nostall: ready=%b, required 1", ready_o);
    end
    tick();
    drive(1, 1, 0, 3, 6, 6);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_br_nostall: ready=%b, required 1", ready_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({valid_o, illegal_o, functionType_o, pRead_o, pWrite_o, sRead_o}
        !== {1'b1, 1'b1, 5'b0}) begin
      n_bad++;
      $display("FAIL illegal_head: valid=%b ill=%b type=%0d, required 1 1 0",
               valid_o, illegal_o, functionType_o);
    end
    wb(1, 6);
    tick();
    wb(0, 0);
    tick();
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive(1, 0, 1, 4, 10, 16'h1234);
    tick();
    drive(1, 0, 1, 5, 11, 16'h00ab);
    tick();
    drive(1, 1, 1, 0, 0, 0);
    n_cmp++;
    if ({ready_o, valid_o, opcode_o, primOperand_o, secOperand_o}
        !== {1'b0, 1'b1, 7'd4, 5'd10, 16'h1234}) begin
      n_bad++;
      $display("FAIL bp_full: ready=%b valid=%b op=%0d prim=%0d",
               ready_o, valid_o, opcode_o, primOperand_o);
    end
    tick();
    n_cmp++;
    if ({opcode_o, primOperand_o} !== {7'd4, 5'd10}) begin
      n_bad++;
      $display("FAIL bp_hold: op=%0d prim=%0d, required 4 10",
               opcode_o, primOperand_o);
    end
    ready_i = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full_pop: ready=%b, required 0", ready_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if ({valid_o, opcode_o} !== {1'b1, 7'd5}) begin
      n_bad++;
      $display("FAIL bp_drain: valid=%b op=%0d, required 1 5", valid_o, opcode_o);
    end
    tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty: valid=%b, required 0", valid_o);
    end
    wb(1, 10);
    tick();
    wb(1, 11);
    tick();
    wb(0, 0);
  endtask

  task automatic test_setclear();
    drive(1, 0, 1, 4, 5, 0);
    tick();
    drive(1, 0, 1, 4, 5, 7);
    wb(1, 5);
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL sc_bypass: ready=%b, required 1", ready_o);
    end
    tick();
    wb(0, 0);
    drive(1, 0, 1, 1, 5, 0);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sc_set_wins: ready=%b, required 0", ready_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 5);
    tick();
    wb(0, 0);
    drive(1, 0, 1, 1, 5, 0);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL sc_cleared: ready=%b, required 1", ready_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 5);
    tick();
    wb(0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 4, 16 + i, i * 257);
      n_cmp++;
      if (ready_o !== 1'b1 || (i > 0 && valid_o !== 1'b1)) begin
        n_bad++;
        $display("FAIL b2b_stream: i=%0d ready=%b valid=%b, required 1 1",
                 i, ready_o, valid_o);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      wb(1, 16 + i);
      tick();
    end
    wb(0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    drive(1, 0, 1, 4, 20, 0);
    tick();
    drive(1, 0, 1, 4, 21, 0);
    tick();
    drive(1, 0, 1, 1, 20, 0);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_pre: ready=%b, required 0", ready_o);
    end
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if ({valid_o, opcode_o, primOperand_o, ready_o}
        !== {1'b0, 7'd0, 5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL rm_async: valid=%b op=%0d prim=%0d ready=%b, required 0 0 0 1",
               valid_o, opcode_o, primOperand_o, ready_o);
    end
    q.delete();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset_i = 1'b0;
    ready_i = 1'b1;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL rm_after: valid=%b queued=%0d, required 0 0",
               valid_o, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_raw();
    test_illegal();
    test_backpressure();
    test_setclear();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
